// File: rtl/maquina_frame_pkg.sv
// rtl/maquina_frame_pkg.sv - shared states, frame constants and CRC-8 step for maquina_frame
// The CRC helper is used only when FRAME_CRC8_EN is defined.
package maquina_frame_pkg;

  typedef enum logic [4:0] {
    ST_IDLE          = 5'd0,
    ST_SEND_SOF      = 5'd1,
    ST_SEND_CMD      = 5'd2,
    ST_SEND_DATA     = 5'd3,
    ST_SEND_CHECKSUM = 5'd4,
    ST_WAIT_SOF      = 5'd5,
    ST_WAIT_STATUS   = 5'd6,
    ST_WAIT_DATA     = 5'd7,
    ST_WAIT_CHECKSUM = 5'd8,
    ST_CHECK         = 5'd9,
    ST_RETRY         = 5'd10,
    ST_DONE          = 5'd11
  } state_t;

  localparam logic [7:0]  SOF_TX        = 8'hAA;
  localparam logic [7:0]  SOF_RX        = 8'h55;
  localparam logic [7:0]  CODE_TIMEOUT  = 8'h01;
  localparam logic [7:0]  CODE_CHECKSUM = 8'h02;
  localparam logic [7:0]  CODE_DEVICE   = 8'h03;
  localparam logic [7:0]  CRC8_POLY     = 8'h07;
  localparam logic [31:0] ERR_WORD_BASE = 32'hFFFF_FF00;

  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_checksum.sv
// rtl/frame_checksum.sv - running frame check byte: additive two's complement, or CRC-8 under FRAME_CRC8_EN
// `value` is always the byte that belongs in the CHK slot for the bytes accumulated so far.
module frame_checksum
  import maquina_frame_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  output logic [7:0] value
);

  logic [7:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = 8'h00;
    end else if (byte_valid) begin
`ifdef FRAME_CRC8_EN
      acc_d = crc8_update(acc_q, byte_in);
`else
      acc_d = acc_q + byte_in;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) acc_q <= 8'h00;
    else        acc_q <= acc_d;
  end

`ifdef FRAME_CRC8_EN
  assign value = acc_q;
`else
  assign value = 8'h00 - acc_q;
`endif

endmodule

// File: rtl/maquina_frame.sv
// rtl/maquina_frame.sv - custom-instruction UART engine: send framed command, hunt/validate reply, retry
// FRAME_CRC8_EN switches the frame check byte from additive checksum to CRC-8.
module maquina_frame
  import maquina_frame_pkg::*;
#(
  parameter int PAYLOAD_BYTES  = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRIES    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done,
  output logic        err,
  output logic [7:0]  txdata,
  output logic        wr_en,
  input  logic        tx_busy,
  input  logic [7:0]  rxdata,
  input  logic        rdy,
  output logic        rdy_clr,
  output logic [4:0]  state
);

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [31:0] datab_q, datab_d;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  retries_q, retries_d;
  logic [7:0]  code_q, code_d;
  logic [7:0]  status_q, status_d;
  logic [7:0]  chk_q, chk_d;
  logic [31:0] payload_q, payload_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  txdata_q, txdata_d;
  logic        wr_en_q, wr_en_d;
  logic        rdy_clr_q, rdy_clr_d;
  logic [1:0]  tx_gap_q, tx_gap_d;
  logic [1:0]  rx_gap_q, rx_gap_d;
  logic [31:0] tmo_q, tmo_d;

  logic [31:0] tmo_next;
  logic        tx_ok, rx_take, tmo_hit, last_idx;
  logic        tx_fire, tx_clr, tx_vld, rx_clr, rx_vld;
  logic [7:0]  tx_byte, tx_chk, rx_chk;
  logic        unused_dataa_hi;

  assign unused_dataa_hi = ^dataa[31:8];

  frame_checksum u_tx_chk (
    .clk        (clk),
    .reset      (reset),
    .clear      (tx_clr),
    .byte_valid (tx_vld),
    .byte_in    (tx_byte),
    .value      (tx_chk)
  );

  frame_checksum u_rx_chk (
    .clk        (clk),
    .reset      (reset),
    .clear      (rx_clr),
    .byte_valid (rx_vld),
    .byte_in    (rxdata),
    .value      (rx_chk)
  );

  // Gap counters cover the strobe cycle and the one after, so a late busy/rdy edge is never misread.
  assign tx_ok    = !tx_busy && (tx_gap_q == 2'd0);
  assign rx_take  = rdy && (rx_gap_q == 2'd0) &&
                    (state_q inside {ST_WAIT_SOF, ST_WAIT_STATUS, ST_WAIT_DATA, ST_WAIT_CHECKSUM});
  assign tmo_next = tmo_q + 32'd1;
  assign tmo_hit  = tmo_next >= 32'(TIMEOUT_CYCLES - 1);
  assign last_idx = idx_q == 2'(PAYLOAD_BYTES - 1);

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    datab_d   = datab_q;
    idx_d     = idx_q;
    retries_d = retries_q;
    code_d    = code_q;
    status_d  = status_q;
    chk_d     = chk_q;
    payload_d = payload_q;
    result_d  = result_q;
    err_d     = err_q;
    txdata_d  = txdata_q;
    tmo_d     = tmo_q;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    rdy_clr_d = 1'b0;
    tx_fire   = 1'b0;
    tx_byte   = 8'h00;
    tx_clr    = 1'b0;
    tx_vld    = 1'b0;
    rx_clr    = 1'b0;
    rx_vld    = 1'b0;
    tx_gap_d  = (tx_gap_q != 2'd0) ? tx_gap_q - 2'd1 : 2'd0;
    rx_gap_d  = (rx_gap_q != 2'd0) ? rx_gap_q - 2'd1 : 2'd0;

    if (rx_take) begin
      rdy_clr_d = 1'b1;
      rx_gap_d  = 2'd2;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cmd_d     = dataa[7:0];
          datab_d   = datab;
          retries_d = 3'd0;
          code_d    = 8'h00;
          state_d   = ST_SEND_SOF;
        end
      end
      ST_SEND_SOF: begin
        if (tx_ok) begin
          tx_fire = 1'b1;
          tx_byte = SOF_TX;
          tx_clr  = 1'b1;
          state_d = ST_SEND_CMD;
        end
      end
      ST_SEND_CMD: begin
        if (tx_ok) begin
          tx_fire = 1'b1;
          tx_byte = cmd_q;
          tx_vld  = 1'b1;
          idx_d   = 2'd0;
          state_d = ST_SEND_DATA;
        end
      end
      ST_SEND_DATA: begin
        if (tx_ok) begin
          tx_fire = 1'b1;
          tx_byte = datab_q[{idx_q, 3'b000} +: 8];
          tx_vld  = 1'b1;
          idx_d   = idx_q + 2'd1;
          if (last_idx) state_d = ST_SEND_CHECKSUM;
        end
      end
      ST_SEND_CHECKSUM: begin
        if (tx_ok) begin
          tx_fire = 1'b1;
          tx_byte = tx_chk;
          tmo_d   = 32'd0;
          state_d = ST_WAIT_SOF;
        end
      end
      // Non-SOF bytes are dropped without restarting the timeout.
      ST_WAIT_SOF: begin
        tmo_d = tmo_next;
        if (rx_take) begin
          if (rxdata == SOF_RX) begin
            rx_clr    = 1'b1;
            payload_d = 32'd0;
            state_d   = ST_WAIT_STATUS;
          end
        end else if (tmo_hit) begin
          code_d  = CODE_TIMEOUT;
          state_d = ST_RETRY;
        end
      end
      ST_WAIT_STATUS: begin
        tmo_d = tmo_next;
        if (rx_take) begin
          status_d = rxdata;
          rx_vld   = 1'b1;
          tmo_d    = 32'd0;
          idx_d    = 2'd0;
          state_d  = ST_WAIT_DATA;
        end else if (tmo_hit) begin
          code_d  = CODE_TIMEOUT;
          state_d = ST_RETRY;
        end
      end
      ST_WAIT_DATA: begin
        tmo_d = tmo_next;
        if (rx_take) begin
          payload_d[{idx_q, 3'b000} +: 8] = rxdata;
          rx_vld = 1'b1;
          tmo_d  = 32'd0;
          idx_d  = idx_q + 2'd1;
          if (last_idx) state_d = ST_WAIT_CHECKSUM;
        end else if (tmo_hit) begin
          code_d  = CODE_TIMEOUT;
          state_d = ST_RETRY;
        end
      end
      ST_WAIT_CHECKSUM: begin
        tmo_d = tmo_next;
        if (rx_take) begin
          chk_d   = rxdata;
          tmo_d   = 32'd0;
          state_d = ST_CHECK;
        end else if (tmo_hit) begin
          code_d  = CODE_TIMEOUT;
          state_d = ST_RETRY;
        end
      end
      ST_CHECK: begin
        if (chk_q != rx_chk) begin
          code_d  = CODE_CHECKSUM;
          state_d = ST_RETRY;
        end else if (status_q != 8'h00) begin
          result_d = ERR_WORD_BASE | {24'h0, CODE_DEVICE};
          err_d    = 1'b1;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end else begin
          result_d = payload_q;
          err_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_RETRY: begin
        if (retries_q < 3'(MAX_RETRIES)) begin
          retries_d = retries_q + 3'd1;
          state_d   = ST_SEND_SOF;
        end else begin
          result_d = ERR_WORD_BASE | {24'h0, code_q};
          err_d    = 1'b1;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (tx_fire) begin
      txdata_d = tx_byte;
      wr_en_d  = 1'b1;
      tx_gap_d = 2'd2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cmd_q     <= 8'h00;
      datab_q   <= 32'd0;
      idx_q     <= 2'd0;
      retries_q <= 3'd0;
      code_q    <= 8'h00;
      status_q  <= 8'h00;
      chk_q     <= 8'h00;
      payload_q <= 32'd0;
      result_q  <= 32'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      txdata_q  <= 8'h00;
      wr_en_q   <= 1'b0;
      rdy_clr_q <= 1'b0;
      tx_gap_q  <= 2'd0;
      rx_gap_q  <= 2'd0;
      tmo_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      datab_q   <= datab_d;
      idx_q     <= idx_d;
      retries_q <= retries_d;
      code_q    <= code_d;
      status_q  <= status_d;
      chk_q     <= chk_d;
      payload_q <= payload_d;
      result_q  <= result_d;
      done_q    <= done_d;
      err_q     <= err_d;
      txdata_q  <= txdata_d;
      wr_en_q   <= wr_en_d;
      rdy_clr_q <= rdy_clr_d;
      tx_gap_q  <= tx_gap_d;
      rx_gap_q  <= rx_gap_d;
      tmo_q     <= tmo_d;
    end
  end

  assign result  = result_q;
  assign done    = done_q;
  assign err     = err_q;
  assign txdata  = txdata_q;
  assign wr_en   = wr_en_q;
  assign rdy_clr = rdy_clr_q;
  assign state   = state_q;

endmodule

// File: tb/tb_maquina_frame.sv
// tb/tb_maquina_frame.sv - directed bench for maquina_frame (default build, additive checksum)
// dut_a: MAX_RETRIES=1, dut_b: MAX_RETRIES=0; both PAYLOAD_BYTES=2, TIMEOUT_CYCLES=100.
module tb_maquina_frame;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [31:0] dataa = 32'd0;
  logic [31:0] datab = 32'd0;
  logic        tx_busy = 1'b0;
  logic [7:0]  rxdata = 8'h00;
  logic        rdy = 1'b0;

  logic [31:0] result_a, result_b;
  logic        done_a, done_b, err_a, err_b, wr_en_a, wr_en_b, rdy_clr_a, rdy_clr_b;
  logic [7:0]  txdata_a, txdata_b;
  logic [4:0]  state_a, state_b;

  int checks = 0;
  int errors = 0;
  logic [7:0] tx_log[$];
  int busy_cnt = 0;
  int rdy_clr_cnt = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  logic [7:0] exp_frame [5] = '{8'hAA, 8'h61, 8'h34, 8'h12, 8'h59};

  always #5 clk = ~clk;

  maquina_frame #(.PAYLOAD_BYTES(2), .TIMEOUT_CYCLES(100), .MAX_RETRIES(1)) dut_a (
    .clk(clk), .reset(reset_n), .start(start_a), .dataa(dataa), .datab(datab),
    .result(result_a), .done(done_a), .err(err_a), .txdata(txdata_a), .wr_en(wr_en_a),
    .tx_busy(tx_busy), .rxdata(rxdata), .rdy(rdy), .rdy_clr(rdy_clr_a), .state(state_a)
  );

  maquina_frame #(.PAYLOAD_BYTES(2), .TIMEOUT_CYCLES(100), .MAX_RETRIES(0)) dut_b (
    .clk(clk), .reset(reset_n), .start(start_b), .dataa(dataa), .datab(datab),
    .result(result_b), .done(done_b), .err(err_b), .txdata(txdata_b), .wr_en(wr_en_b),
    .tx_busy(tx_busy), .rxdata(rxdata), .rdy(rdy), .rdy_clr(rdy_clr_b), .state(state_b)
  );

  // UART TX model and pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en_a) tx_log.push_back(txdata_a);
    if (wr_en_b) tx_log.push_back(txdata_b);
    if (wr_en_a || wr_en_b) busy_cnt = 3;
    else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    tx_busy = (busy_cnt != 0);
    if (rdy_clr_a) rdy_clr_cnt = rdy_clr_cnt + 1;
    if (done_a) done_cnt_a = done_cnt_a + 1;
    if (done_b) done_cnt_b = done_cnt_b + 1;
  end

  task automatic pulse_start(input int sel, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dataa = a;
    datab = b;
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    dataa = 32'h0000_0062;
    datab = 32'h0000_0000;
  endtask

  task automatic wait_tx(input int n);
    int i;
    for (i = 0; i < 500 && tx_log.size() < n; i++) @(negedge clk);
    checks++;
    if (tx_log.size() < n) begin
      errors++;
      $display("FAIL wait_tx: got %0d bytes, required %0d", tx_log.size(), n);
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    bit got;
    got = 1'b0;
    @(negedge clk);
    rxdata = b;
    rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rdy_clr_a) begin
        got = 1'b1;
        break;
      end
    end
    rdy = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rx_handshake byte %02h: rdy_clr=0, required 1", b);
    end
  endtask

  task automatic send_reply(input logic [7:0] b0, b1, b2, b3, b4);
    send_rx(b0); send_rx(b1); send_rx(b2); send_rx(b3); send_rx(b4);
  endtask

  task automatic wait_done_a(output logic [31:0] res, output logic e);
    int i;
    res = 32'hxxxx_xxxx;
    e = 1'bx;
    for (i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done_a) begin
        res = result_a;
        e = err_a;
        break;
      end
    end
    checks++;
    if (i >= 500) begin
      errors++;
      $display("FAIL wait_done: done=0, required 1");
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (result_a !== 32'd0) begin errors++; $display("FAIL reset_result: got %h, required 0", result_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done_a); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", err_a); end
    checks++; if (txdata_a !== 8'h00) begin errors++; $display("FAIL reset_txdata: got %h, required 00", txdata_a); end
    checks++; if (wr_en_a !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b, required 0", wr_en_a); end
    checks++; if (rdy_clr_a !== 1'b0) begin errors++; $display("FAIL reset_rdy_clr: got %b, required 0", rdy_clr_a); end
    checks++; if (state_a !== 5'd0) begin errors++; $display("FAIL reset_state_a: got %0d, required 0", state_a); end
    checks++; if (state_b !== 5'd0) begin errors++; $display("FAIL reset_state_b: got %0d, required 0", state_b); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_happy_path();
    logic [31:0] res;
    logic e;
    int d0;
    tx_log.delete();
    rdy_clr_cnt = 0;
    d0 = done_cnt_a;
    pulse_start(0, 32'hDEAD_BE61, 32'h5A5A_1234);
    wait_tx(5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (tx_log[i] !== exp_frame[i]) begin
        errors++;
        $display("FAIL happy_tx_byte%0d: got %h, required %h", i, tx_log[i], exp_frame[i]);
      end
    end
    send_reply(8'h55, 8'h00, 8'hCD, 8'hAB, 8'h88);
    wait_done_a(res, e);
    checks++; if (res !== 32'h0000_ABCD) begin errors++; $display("FAIL happy_result: got %h, required 0000abcd", res); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL happy_err: got %b, required 0", e); end
    repeat (6) @(negedge clk);
    checks++; if (done_cnt_a !== d0 + 1) begin errors++; $display("FAIL happy_done_pulses: got %0d, required %0d", done_cnt_a - d0, 1); end
    checks++; if (state_a !== 5'd0) begin errors++; $display("FAIL happy_idle: got %0d, required 0", state_a); end
    checks++; if (result_a !== 32'h0000_ABCD) begin errors++; $display("FAIL happy_result_hold: got %h, required 0000abcd", result_a); end
    checks++; if (rdy_clr_cnt !== 5) begin errors++; $display("FAIL happy_rdy_clr: got %0d, required 5", rdy_clr_cnt); end
  endtask

  task automatic test_noise_hunting();
    logic [31:0] res;
    logic e;
    tx_log.delete();
    rdy_clr_cnt = 0;
    pulse_start(0, 32'h0000_0061, 32'h0000_1234);
    wait_tx(5);
    send_rx(8'h00);
    send_rx(8'h13);
    send_reply(8'h55, 8'h00, 8'hCD, 8'hAB, 8'h88);
    wait_done_a(res, e);
    checks++; if (res !== 32'h0000_ABCD) begin errors++; $display("FAIL noise_result: got %h, required 0000abcd", res); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL noise_err: got %b, required 0", e); end
    repeat (6) @(negedge clk);
    checks++; if (rdy_clr_cnt !== 7) begin errors++; $display("FAIL noise_rdy_clr: got %0d, required 7", rdy_clr_cnt); end
  endtask

  task automatic test_bad_checksum();
    logic [31:0] res;
    logic e;
    tx_log.delete();
    pulse_start(0, 32'h0000_0061, 32'h0000_1234);
    wait_tx(5);
    send_reply(8'h55, 8'h00, 8'hCD, 8'hAB, 8'h00);
    wait_tx(10);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (tx_log[5 + i] !== exp_frame[i]) begin
        errors++;
        $display("FAIL resend_tx_byte%0d: got %h, required %h", i, tx_log[5 + i], exp_frame[i]);
      end
    end
    send_reply(8'h55, 8'h00, 8'hCD, 8'hAB, 8'h00);
    wait_done_a(res, e);
    checks++; if (res !== 32'hFFFF_FF02) begin errors++; $display("FAIL badchk_result: got %h, required ffffff02", res); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL badchk_err: got %b, required 1", e); end
    repeat (10) @(negedge clk);
    checks++; if (tx_log.size() !== 10) begin errors++; $display("FAIL badchk_tx_count: got %0d, required 10", tx_log.size()); end
  endtask

  task automatic test_device_error();
    logic [31:0] res;
    logic e;
    tx_log.delete();
    pulse_start(0, 32'h0000_0061, 32'h0000_1234);
    wait_tx(5);
    send_reply(8'h55, 8'h07, 8'h00, 8'h00, 8'hF9);
    wait_done_a(res, e);
    checks++; if (res !== 32'hFFFF_FF03) begin errors++; $display("FAIL deverr_result: got %h, required ffffff03", res); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL deverr_err: got %b, required 1", e); end
    repeat (10) @(negedge clk);
    checks++; if (tx_log.size() !== 5) begin errors++; $display("FAIL deverr_no_retry: got %0d bytes, required 5", tx_log.size()); end
  endtask

  task automatic test_timeout();
    bit found;
    int n;
    logic [31:0] res;
    logic e;
    tx_log.delete();
    found = 1'b0;
    pulse_start(1, 32'h0000_0061, 32'h0000_1234);
    for (int i = 0; i < 500; i++) begin
      if (state_b == 5'd5) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL timeout_wait_sof: state %0d, required 5", state_b); end
    n = 0;
    while (!done_b && n < 300) begin
      @(negedge clk);
      n++;
    end
    res = result_b;
    e = err_b;
    checks++; if (n !== 100) begin errors++; $display("FAIL timeout_cycles: got %0d, required 100", n); end
    checks++; if (res !== 32'hFFFF_FF01) begin errors++; $display("FAIL timeout_result: got %h, required ffffff01", res); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b, required 1", e); end
    repeat (5) @(negedge clk);
    checks++; if (tx_log.size() !== 5) begin errors++; $display("FAIL timeout_no_retry: got %0d bytes, required 5", tx_log.size()); end
  endtask

  task automatic test_reset_mid_frame();
    bit found;
    int sz;
    logic [31:0] res;
    logic e;
    found = 1'b0;
    pulse_start(0, 32'h0000_0061, 32'h0000_1234);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (state_a == 5'd3) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL midrst_reach_send_data: state %0d, required 3", state_a); end
    reset_n = 1'b0;
    #1;
    checks++; if (state_a !== 5'd0) begin errors++; $display("FAIL midrst_state: got %0d, required 0", state_a); end
    checks++; if (result_a !== 32'd0) begin errors++; $display("FAIL midrst_result: got %h, required 0", result_a); end
    checks++; if (wr_en_a !== 1'b0 || txdata_a !== 8'h00) begin errors++; $display("FAIL midrst_tx: got wr_en=%b txdata=%h, required 0/00", wr_en_a, txdata_a); end
    checks++; if (done_a !== 1'b0 || err_a !== 1'b0 || rdy_clr_a !== 1'b0) begin errors++; $display("FAIL midrst_flags: got done=%b err=%b rdy_clr=%b, required 0", done_a, err_a, rdy_clr_a); end
    sz = tx_log.size();
    repeat (4) @(negedge clk);
    checks++; if (tx_log.size() !== sz) begin errors++; $display("FAIL midrst_no_write: got %0d bytes, required %0d", tx_log.size(), sz); end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    tx_log.delete();
    pulse_start(0, 32'h0000_0061, 32'h0000_1234);
    wait_tx(5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (tx_log[i] !== exp_frame[i]) begin
        errors++;
        $display("FAIL midrst_tx_byte%0d: got %h, required %h", i, tx_log[i], exp_frame[i]);
      end
    end
    send_reply(8'h55, 8'h00, 8'hCD, 8'hAB, 8'h88);
    wait_done_a(res, e);
    checks++; if (res !== 32'h0000_ABCD || e !== 1'b0) begin errors++; $display("FAIL midrst_result_after: got %h err=%b, required 0000abcd err=0", res, e); end
  endtask

  initial begin
    test_reset();
    test_happy_path();
    test_noise_hunting();
    test_bad_checksum();
    test_device_error();
    test_timeout();
    test_reset_mid_frame();
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/maquina_frame.md
# maquina_frame

Parametrised successor of the UART custom-instruction state machine. On a Nios custom-instruction start it sends a framed, checksummed command over the UART byte interface. It then hunts for and validates the response frame, retrying on timeout or checksum failure. It returns the response payload on `result` with a one-cycle `done`, and sits between the custom-instruction port and the UART TX/RX cores.

## Interface
- PAYLOAD_BYTES, 2: payload bytes per frame, each direction; legal 1..4.
- TIMEOUT_CYCLES, 50000: idle clk cycles allowed before a response byte arrives.
- MAX_RETRIES, 2: frame resends after the first attempt; legal 0..7.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  custom-instruction start; sampled only in IDLE.
- dataa  in  32  `[7:0]` is the command byte; `[31:8]` is ignored.
- datab  in  32  TX payload, little-endian; low PAYLOAD_BYTES bytes are used.
- result  out  32  response payload, zero-extended, or an error word.
- done  out  1  one-cycle completion strobe.
- err  out  1  valid with `done`; 1 = `result` is an error word.
- txdata  out  8  byte to the UART TX.
- wr_en  out  1  one-cycle TX write strobe.
- tx_busy  in  1  UART TX busy.
- rxdata  in  8  received byte.
- rdy  in  1  UART RX byte-ready.
- rdy_clr  out  1  one-cycle RX ready-clear.
- state  out  5  current state encoding, for debug and benches.

## Operation
- TX frame: 0xAA, CMD, payload bytes LSB first, CHK.
- RX frame: 0x55, STATUS, payload bytes LSB first, CHK.
- CHK: two's complement of the 8-bit sum of every byte after SOF, so that byte sum including CHK ≡ 0 mod 256.
- Inputs `dataa` and `datab` are latched on the accepted start. Later changes are ignored. `start` outside IDLE is ignored.
- States and encodings:
  - IDLE=0, SEND_SOF=1, SEND_CMD=2, SEND_DATA=3, SEND_CHECKSUM=4.
  - WAIT_SOF=5, WAIT_STATUS=6, WAIT_DATA=7, WAIT_CHECKSUM=8.
  - CHECK=9, RETRY=10, DONE=11.
- SEND_DATA and WAIT_DATA loop on a byte index 0..PAYLOAD_BYTES-1.
- WAIT_SOF discards any byte other than 0x55 (noise hunting). The timeout is not restarted by discarded bytes.
- CHECK outcomes:
  - Checksum bad → RETRY (code 0x02).
  - Checksum good, STATUS≠0 → DONE with error 0x03, no retry.
  - Checksum good, STATUS=0 → DONE with payload.
- Timeout in any WAIT_* state → RETRY (code 0x01).
- RETRY: if retries used < MAX_RETRIES, increment and go to SEND_SOF (full resend). Otherwise go to DONE with the last code.
- Error word: 32'hFFFF_FF00 | code; `err`=1.
- Reset values: `result`=0, `done`=0, `err`=0, `txdata`=0, `wr_en`=0, `rdy_clr`=0, `state`=IDLE. The retry counter and all latches are cleared.
- Reset mid-frame aborts immediately. No partial `done` is produced, and no further bytes are written.

## Timing
- TX byte handshake:
  - In a SEND state, wait for `tx_busy`=0.
  - Drive `txdata` and pulse `wr_en` for exactly one cycle.
  - Hold `txdata` stable that cycle and the next.
  - Do not sample `tx_busy` again until one cycle after `wr_en`, which tolerates a one-cycle-late busy rise.
- RX byte handshake:
  - On `rdy`=1, capture `rxdata` that cycle and pulse `rdy_clr` the following cycle.
  - `rdy` is ignored during the `rdy_clr` cycle and the cycle after.
- Timeout counter: cleared on entry to WAIT_SOF and on every captured byte in WAIT_STATUS/DATA/CHECKSUM. It expires when it reaches TIMEOUT_CYCLES-1.
- CHECK takes one cycle after the CHK capture. DONE lasts one cycle: `done`=1 with `result`/`err` valid.
- `result` holds its value until the next DONE. The machine returns to IDLE the cycle after DONE.
- A `start` held high in the IDLE cycle after DONE begins a new transaction.
- Simultaneous timeout expiry and `rdy` in the same cycle: the byte wins and the timeout is discarded.

## Configuration
- FRAME_CRC8_EN:
  - Defined: CHK is CRC-8 (poly 0x07, init 0x00, MSB first, no final XOR) over CMD/STATUS and payload bytes. The received CHK must equal the computed CRC.
  - Undefined: the additive two's-complement checksum above is used.
- Frame layout, states and timing are identical in both builds.

## Structure
- Package `maquina_frame_pkg` contains:
  - the state enum and its encodings;
  - SOF constants 0xAA and 0x55;
  - error codes 0x01, 0x02 and 0x03;
  - the CRC polynomial constant.
- Sub-module `frame_checksum` accumulates the checksum:
  - ports: clear, byte-valid, byte, and the running value;
  - additive or CRC-8 selected by FRAME_CRC8_EN;
  - one instance each for TX and RX.

## Test plan
- Happy path (PAYLOAD_BYTES=2, dataa=0x61, datab=0x1234): expect TX bytes AA 61 34 12 59. Reply 55 00 CD AB 88 → `result`=0x0000ABCD, `err`=0, one `done` pulse.
- Noise hunting: bytes 00 13 before the reply above are discarded, with the same result; `rdy_clr` pulses once per byte, 7 pulses total.
- Bad checksum, MAX_RETRIES=1: first reply with CHK=00 → full frame resent; second reply also bad → `result`=0xFFFFFF02, `err`=1.
- Timeout, TIMEOUT_CYCLES=100, MAX_RETRIES=0: no reply → `done` exactly 100 cycles after WAIT_SOF entry, `result`=0xFFFFFF01.
- Device error: reply 55 07 00 00 F9 → `result`=0xFFFFFF03, no retry.
- Reset mid-frame: drive `reset` low during SEND_DATA → all outputs at reset values, `state`=0; next `start` sends a clean frame from 0xAA.
